cache_arbiter: RTL

- Sits directly downstream of the two pipelined caches (I-cache, D-cache); multiplexes their physical-memory ports onto the single cacheline adaptor.
- Serves one 256-bit line transaction at a time and routes pmem_resp/pmem_rdata back to the granted cache only.
- Fair arbitration: when both caches request at once, the one not served last wins.
- I-cache side is read-only; D-cache side does line reads (fills) and line writes (writebacks).

---
 rtl/cache_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Two-cache to one-adaptor line arbiter: one 256-bit transaction at a time,
// alternating grants under contention, responses routed to the granted cache.
module cache_arbiter #(
   parameter int s_line = 256,
   parameter int s_addr = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pmem_read,
   input  logic [s_addr-1:0] i_pmem_address,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_addr-1:0] d_pmem_address,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t state;
   logic   last_d;
   logic   d_req;
   logic   i_req;

   assign d_req = d_pmem_read | d_pmem_write;
   assign i_req = i_pmem_read;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // D wins a tie only when I was served last
               if (d_req && (!i_req || !last_d))
                  state <= SERVE_D;
               else if (i_req)
                  state <= SERVE_I;
            end
            SERVE_I: begin
               if (pmem_resp) begin
                  state  <= DONE;
                  last_d <= 1'b0;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  state  <= DONE;
                  last_d <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      unique case (state)
         SERVE_I: begin
            pmem_read    = i_pmem_read;
            pmem_address = i_pmem_address;
            i_pmem_resp  = pmem_resp;
         end
         SERVE_D: begin
            pmem_read    = d_pmem_read;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
            d_pmem_resp  = pmem_resp;
         end
         default: ;
      endcase
   end

endmodule
